// File: rtl/ps_pkg.sv
// rtl/ps_pkg.sv - shared constants and state type for the serializer/deserializer pair
package ps_pkg;

  // Idle/alignment character used by both link partners
  localparam logic [7:0] COM_CHAR_DEFAULT       = 8'hBC;
  localparam int         PREAMBLE_COUNT_DEFAULT = 4;
  localparam int         BIT_IDX_W              = 3;

  typedef enum logic {
    PREAMBLE = 1'b0,
    RUN      = 1'b1
  } ps_state_e;

endpackage

// File: rtl/ps_bit_counter.sv
// rtl/ps_bit_counter.sv - free-running bit position counter with load edge flag
module ps_bit_counter
  import ps_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  output logic [BIT_IDX_W-1:0] count,
  output logic                 load_edge
);

  // Bit position within the current byte; natural overflow gives the 7->0 wrap
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

  // The edge following count==0 starts a new byte
  assign load_edge = (count == '0);

endmodule

// File: rtl/paralelo_serial.sv
// rtl/paralelo_serial.sv - byte to MSB-first serial transmitter with COM preamble/fill (option: PS_BYTE_COUNT_EN)
module paralelo_serial
  import ps_pkg::*;
#(
  parameter logic [7:0] COM_CHAR       = COM_CHAR_DEFAULT,
  parameter int         PREAMBLE_COUNT = PREAMBLE_COUNT_DEFAULT
) (
  input  logic        clk_32f,
  input  logic        reset,
  input  logic [7:0]  data_in,
  input  logic        valid_in,
  output logic        in_ready,
  output logic        data_out,
  output logic        byte_start,
`ifdef PS_BYTE_COUNT_EN
  output logic [15:0] tx_count,
`endif
  output logic        link_up
);

  ps_state_e            state;
  logic [3:0]           com_cnt;
  logic [7:0]           cur;
  logic [BIT_IDX_W-1:0] bit_idx;
  logic                 load_edge;
  logic [7:0]           next_byte;
  logic                 take_data;

  ps_bit_counter u_bit_counter (
    .clk       (clk_32f),
    .reset     (reset),
    .count     (bit_idx),
    .load_edge (load_edge)
  );

  // Pick the byte for the next slot: user data only once the link is up
  always_comb begin
    take_data = (state == RUN) && valid_in;
    next_byte = take_data ? data_in : COM_CHAR;
  end

  assign in_ready = (state == RUN) && load_edge && !reset;

  // Shift register, framing marker and preamble/run sequencing
  always_ff @(posedge clk_32f) begin
    if (reset) begin
      state      <= PREAMBLE;
      com_cnt    <= 4'd0;
      cur        <= 8'h00;
      data_out   <= 1'b0;
      byte_start <= 1'b0;
      link_up    <= 1'b0;
    end else begin
      if (load_edge) begin
        cur        <= next_byte;
        data_out   <= next_byte[7];
        byte_start <= 1'b1;
        if (state == PREAMBLE) begin
          com_cnt <= com_cnt + 4'd1;
          if (com_cnt == 4'(PREAMBLE_COUNT - 1)) begin
            state   <= RUN;
            link_up <= 1'b1;
          end
        end
      end else begin
        data_out   <= cur[3'd7 - bit_idx];
        byte_start <= 1'b0;
      end
    end
  end

`ifdef PS_BYTE_COUNT_EN
  // Count user bytes actually transmitted, saturating
  always_ff @(posedge clk_32f) begin
    if (reset) begin
      tx_count <= 16'd0;
    end else if (load_edge && take_data && (tx_count != 16'hFFFF)) begin
      tx_count <= tx_count + 16'd1;
    end
  end
`endif

endmodule
